// File: rtl/fifo_ptr_pkg.sv
// Shared pointer definitions and Gray-code helpers for the dual-clock FIFO.
package fifo_ptr_pkg;

    localparam int unsigned ADDRSIZE_DEF = 4;
    localparam int unsigned PTR_W        = ADDRSIZE_DEF + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    // Binary to reflected Gray code.
    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Width-parameterized combinational Gray-to-binary converter (XOR prefix chain).
module gray2bin_conv #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the reduction XOR of the Gray bits from it upward.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/wptr_full_level.sv
// Write-side pointer, full/almost-full, fill level and overflow for the async FIFO.
// Optional almost-full logic is enabled by defining WPTR_FULL_LEVEL_AFULL_EN.
module wptr_full_level
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned ADDRSIZE = ADDRSIZE_DEF
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   afull_thresh,
    input  logic                wovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam int unsigned PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wptr_q,   wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q,  wfull_d;
    logic          wovf_q,   wovf_d;
    logic [PW-1:0] rbin_s;

    // Synchronized read pointer back to binary for the level subtraction.
    gray2bin_conv #(.W(PW)) u_rptr_g2b (
        .gray_i (wq2_rptr),
        .bin_o  (rbin_s)
    );

    assign wen = winc & ~wfull_q;

    // Next-state pointer, level and flags, all derived from the post-write pointer.
    always_comb begin
        wbin_d   = wbin_q + PW'(wen);
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        wlevel_d = wbin_d - rbin_s;
        wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wovf_d   = wovf_q;
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end
    end

    // Write-domain state registers with synchronous reset.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wovf_q   <= wovf_d;
        end
    end

`ifdef WPTR_FULL_LEVEL_AFULL_EN
    logic wafull_q, wafull_d;

    // Almost-full compares the post-write level against the threshold.
    always_comb begin
        wafull_d = (wlevel_d >= afull_thresh);
    end

    // Almost-full register.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wafull_q <= 1'b0;
        end else begin
            wafull_q <= wafull_d;
        end
    end

    assign wafull = wafull_q;
`else
    logic unused_afull_thresh;
    assign unused_afull_thresh = ^afull_thresh;
    assign wafull              = 1'b0;
`endif

    assign waddr  = wbin_q[ADDRSIZE-1:0];
    assign wptr   = wptr_q;
    assign wfull  = wfull_q;
    assign wlevel = wlevel_q;
    assign wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed self-checking bench for wptr_full_level (ADDRSIZE=4).
module tb_wptr_full_level;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [4:0] afull_thresh;
    logic       wovf_clr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       wafull;
    logic [4:0] wlevel;
    logic       wovf;

    int n_cmp = 0;
    int n_err = 0;

`ifdef WPTR_FULL_LEVEL_AFULL_EN
    localparam logic AF = 1'b1;
`else
    localparam logic AF = 1'b0;
`endif

    wptr_full_level #(.ADDRSIZE(4)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .afull_thresh (afull_thresh),
        .wovf_clr     (wovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .wafull       (wafull),
        .wlevel       (wlevel),
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        wrst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        wrst_n = 1'b1;
    endtask

    initial begin
        wrst_n       = 1'b0;
        winc         = 1'b1;
        wq2_rptr     = 5'b00000;
        afull_thresh = 5'd12;
        wovf_clr     = 1'b0;

        // Reset with winc held high.
        do_reset(2);
        check("rst_wptr",   32'(wptr),   32'h0);
        check("rst_waddr",  32'(waddr),  32'h0);
        check("rst_wlevel", 32'(wlevel), 32'h0);
        check("rst_wfull",  32'(wfull),  32'h0);
        check("rst_wafull", 32'(wafull), 32'h0);
        check("rst_wovf",   32'(wovf),   32'h0);
        check("rst_wen",    32'(wen),    32'h1);

        // Fill 16 entries.
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 1)  check("fill1_wptr",  32'(wptr), 32'h01);
            if (i == 11) check("fill11_wafull", 32'(wafull), 32'h0);
            if (i == 12) check("fill12_wafull", 32'(wafull), 32'(AF));
            if (i == 15) check("fill15_wfull", 32'(wfull), 32'h0);
        end
        check("full_wfull",  32'(wfull),  32'h1);
        check("full_wlevel", 32'(wlevel), 32'd16);
        check("full_wptr",   32'(wptr),   32'b11000);
        check("full_waddr",  32'(waddr),  32'h0);

        // Overflow: dropped write sets sticky flag.
        check("ovf_wen", 32'(wen), 32'h0);
        tick();
        check("ovf_wptr",   32'(wptr),   32'b11000);
        check("ovf_wlevel", 32'(wlevel), 32'd16);
        check("ovf_wovf",   32'(wovf),   32'h1);
        wovf_clr = 1'b1;
        tick();
        check("ovf_setwins", 32'(wovf), 32'h1);
        winc = 1'b0;
        tick();
        check("ovf_clr", 32'(wovf), 32'h0);
        wovf_clr = 1'b0;
        winc     = 1'b1;
        tick();
        check("ovf_reset", 32'(wovf), 32'h1);

        // Mid-operation reset while full and overflowed.
        winc = 1'b0;
        do_reset(1);
        check("mid_wptr",  32'(wptr),  32'h0);
        check("mid_wfull", 32'(wfull), 32'h0);
        check("mid_wovf",  32'(wovf),  32'h0);
        check("mid_wlevel",32'(wlevel),32'h0);
        winc = 1'b1;
        tick();
        check("mid_waddr", 32'(waddr), 32'h1);
        check("mid_wptr1", 32'(wptr),  32'b00001);

        // Almost-full then read pointer advance to gray 2.
        do_reset(1);
        for (int i = 0; i < 12; i++) tick();
        check("af_wafull", 32'(wafull), 32'(AF));
        check("af_wlevel", 32'(wlevel), 32'd12);
        winc     = 1'b0;
        wq2_rptr = 5'b00011;
        tick();
        check("af_rd_wlevel", 32'(wlevel), 32'd10);
        check("af_rd_wafull", 32'(wafull), 32'h0);

        // Wrap: drive wbin to 31 with reads chasing, then wrap to 0.
        wq2_rptr = 5'b00000;
        winc     = 1'b1;
        do_reset(1);
        for (int i = 0; i < 16; i++) tick();
        winc     = 1'b0;
        wq2_rptr = 5'b11000;
        tick();
        check("wr_rd_wlevel", 32'(wlevel), 32'd0);
        check("wr_rd_wfull",  32'(wfull),  32'h0);
        winc = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        winc     = 1'b0;
        wq2_rptr = 5'b10010;
        tick();
        check("wr31_waddr",  32'(waddr),  32'd15);
        check("wr31_wptr",   32'(wptr),   32'b10000);
        check("wr31_wlevel", 32'(wlevel), 32'd3);
        winc = 1'b1;
        tick();
        check("wrap_waddr",  32'(waddr),  32'h0);
        check("wrap_wptr",   32'(wptr),   32'h0);
        check("wrap_wlevel", 32'(wlevel), 32'd4);
        check("wrap_wfull",  32'(wfull),  32'h0);
        check("wrap_wafull", 32'(wafull), 32'h0);

        // Zero threshold: almost-full from the first edge after reset.
        winc         = 1'b0;
        wq2_rptr     = 5'b00000;
        afull_thresh = 5'd0;
        do_reset(1);
        check("th0_rst_wafull", 32'(wafull), 32'h0);
        tick();
        check("th0_wafull", 32'(wafull), 32'(AF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wptr_full_level.md
# wptr_full_level

Write-side pointer and status block for the dual-clock FIFO. It sits in the write clock domain and owns the binary write address and the Gray-coded write pointer, which is sent to the read domain through the two-flop synchronizer. It also produces the full flag, a gated memory write enable, a fill-level count, an optional almost-full flag and a sticky overflow flag. The comparison uses the read pointer after it has been synchronized into the write domain.

## Interface
- ADDRSIZE, 4, memory address bits; FIFO depth is 2^ADDRSIZE; legal range is ADDRSIZE >= 2
- wclk  in  1  write clock; the block's only clock
- wrst_n  in  1  reset, synchronous, active-low
- winc  in  1  write request
- wq2_rptr  in  ADDRSIZE+1  read pointer, Gray-coded, already synchronized to wclk
- afull_thresh  in  ADDRSIZE+1  almost-full threshold, in entries
- wovf_clr  in  1  clears wovf
- wen  out  1  memory write enable, combinational, equal to winc & ~wfull
- waddr  out  ADDRSIZE  binary write address, equal to wbin[ADDRSIZE-1:0]
- wptr  out  ADDRSIZE+1  Gray write pointer, registered
- wfull  out  1  full flag, registered
- wafull  out  1  almost-full flag, registered
- wlevel  out  ADDRSIZE+1  occupancy as seen from the write side, range 0..2^ADDRSIZE
- wovf  out  1  sticky flag: a write was attempted while full

## Operation
- Internal register wbin, ADDRSIZE+1 bits.
- wbinnext = wbin + wen. Addition is modulo 2^(ADDRSIZE+1).
- wgraynext = (wbinnext >> 1) ^ wbinnext.
- rbin_s = gray-to-binary of wq2_rptr, computed combinationally.
- wlevel_next = wbinnext - rbin_s, modulo 2^(ADDRSIZE+1).
- wfull_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- wafull_val = (wlevel_next >= afull_thresh).
- On every wclk edge with wrst_n high, these registers load together: wbin, wptr, wfull, wafull, wlevel.
- wovf:
  - Set on an edge where winc & wfull.
  - Otherwise cleared on an edge where wovf_clr is high.
  - If set and clear occur on the same edge, set wins.
- A write while full is dropped: wen=0, and wbin and wptr hold.
- Pointer wrap (wbin going 2^(ADDRSIZE+1)-1 -> 0) is seamless. wlevel stays correct across the wrap because of the modular subtraction.
- Simultaneous write and read-pointer change: both are folded into the same next-state computation. No special case.

## Timing
- Reset, applied on a wclk edge with wrst_n low:
  - wbin=0, wptr=0, wfull=0, wafull=0, wlevel=0, wovf=0.
  - wen is combinational, so it follows winc during reset.
- Write-side latency:
  - A write accepted at edge N appears in wptr, wlevel and wfull at edge N.
  - No extra cycle; flags are computed from the next-state pointer.
- Read-side latency:
  - A read becomes visible only when wq2_rptr changes, i.e. 2 wclk after the read domain updates rptr.
  - The resulting wfull, wafull and wlevel update on the following edge.
  - wfull is therefore pessimistic: it may stay set late, but it is never released early.
- afull_thresh = 0: wafull=1 from the first edge after reset.
- Reset asserted mid-operation: all registers clear on that edge, regardless of winc or wfull.

## Configuration
- Macro: WPTR_FULL_LEVEL_AFULL_EN.
- Defined: the wafull logic and the afull_thresh compare are present, as described above.
- Undefined:
  - wafull is tied to 0.
  - afull_thresh is ignored.
  - No comparator or wafull register is synthesized.
  - wlevel, wfull and wovf are unaffected.

## Structure
- Shared package fifo_ptr_pkg contains:
  - The ADDRSIZE default constant.
  - Functions bin2gray and gray2bin.
  - The pointer width definition, ADDRSIZE+1.
- One sub-module, gray2bin_conv:
  - Parameterized by width.
  - Purely combinational XOR prefix chain.
  - Instantiated once to compute rbin_s.
  - The read-domain block reuses it.

## Test plan
All scenarios use ADDRSIZE=4 (depth 16).
- Reset: hold wrst_n=0 for 2 edges with winc=1 -> wptr=0, waddr=0, wlevel=0, wfull=0, wafull=0, wovf=0.
- Fill: wq2_rptr=0, 16 consecutive winc -> after 16th edge wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
- Overflow: while full, winc=1 for 1 cycle -> wen=0, wptr stays 5'b11000, wovf=1. Then assert wovf_clr together with winc -> wovf stays 1. Then assert wovf_clr alone -> wovf=0.
- Almost-full (macro defined): afull_thresh=12.
  - After the 12th write, wafull=1.
  - Then set wq2_rptr=5'b00011 (gray 2) with no writes -> next edge wlevel=10, wafull=0.
- Wrap: reach wbin=31 with wq2_rptr=5'b10010 (gray 28), so wlevel=3. Then write once -> waddr=0, wptr=0, wlevel=4, wfull=0.
- Mid-operation reset: wfull=1, wovf=1, wrst_n=0 for 1 edge -> all registers 0. Then write once -> waddr=1, wptr=5'b00001.
- Macro undefined: rerun the almost-full scenario -> wafull stays 0 throughout.
